// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the multi-port register file: the controller state
// encoding and the default geometry / stack-pointer constants.
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_pkg;

    // CLEAR walks every entry writing its post-reset value; RUN is normal use.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

    localparam int unsigned DEF_DATA_W  = 32;
    localparam int unsigned DEF_ADDR_W  = 5;
    localparam int unsigned DEF_SP_IDX  = 29;
    localparam int unsigned DEF_SP_INIT = 252;

endpackage

// File: rtl/regfile_read_port.sv
// -----------------------------------------------------------------------------
// regfile_read_port
// One combinational read lane: forces zero while initialising or when the
// zero register is addressed, and optionally forwards the write in flight.
//
// Ports:
//   rd_addr_i  in   ADDR_W  index being read on this lane
//   rd_raw_i   in   DATA_W  array content at rd_addr_i
//   run_i      in   1       controller is in RUN
//   wr_en_i    in   1       a user write will commit on the next edge
//   wr_addr_i  in   ADDR_W  index of that write
//   wr_data_i  in   DATA_W  data of that write
//   rd_data_o  out  DATA_W  lane result
// -----------------------------------------------------------------------------
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned BYPASS = 1
) (
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] rd_raw_i,
    input  logic              run_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o
);

    always_comb begin
        // NOTE: assigning a default first means every path drives the output,
        // so no latch can be inferred.
        rd_data_o = rd_raw_i;
        if (!run_i || rd_addr_i == '0) begin
            rd_data_o = '0;
        end else if (BYPASS != 0 && wr_en_i && wr_addr_i == rd_addr_i) begin
            rd_data_o = wr_data_i;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
// Register file with one write port and NUM_RD combinational read ports.
// After reset a CLEAR phase walks all entries (stack pointer gets SP_INIT,
// everything else 0) before 'ready' rises and normal writes are accepted.
//
// Ports:
//   clk            in   1              rising-edge clock
//   rst            in   1              synchronous, active-high reset
//   RegWrite       in   1              write enable
//   WriteRegister  in   ADDR_W         write index
//   WriteData      in   DATA_W         write data
//   ReadRegister   in   NUM_RD*ADDR_W  read indices, lane k at [k*ADDR_W +: ADDR_W]
//   ReadData       out  NUM_RD*DATA_W  read data,    lane k at [k*DATA_W +: DATA_W]
//   ready          out  1              initialisation complete
// -----------------------------------------------------------------------------
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int unsigned DATA_W  = DEF_DATA_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned NUM_RD  = 2,
    parameter int unsigned BYPASS  = 1,
    parameter int unsigned SP_IDX  = DEF_SP_IDX,
    parameter int unsigned SP_INIT = DEF_SP_INIT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     RegWrite,
    input  logic [ADDR_W-1:0]        WriteRegister,
    input  logic [DATA_W-1:0]        WriteData,
    input  logic [NUM_RD*ADDR_W-1:0] ReadRegister,
    output logic [NUM_RD*DATA_W-1:0] ReadData,
    output logic                     ready
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic              ready_q;

    logic              run;
    logic              user_wr;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign run   = (state_q == RUN);
    assign ready = ready_q;

    // A user write that will really commit; also what read lanes forward.
    assign user_wr = run && !rst && RegWrite && (WriteRegister != '0);

    // Single write port shared by the CLEAR walker and user writes.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = WriteRegister;
        mem_wdata = WriteData;
        if (!rst) begin
            if (state_q == CLEAR) begin
                mem_we    = 1'b1;
                mem_waddr = idx_q;
                // Full-width compare: an SP_IDX outside the array selects nothing.
                mem_wdata = (32'(idx_q) == SP_IDX) ? DATA_W'(SP_INIT) : '0;
            end else begin
                mem_we = user_wr;
            end
        end
    end

    // Controller: state, walk index and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            idx_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            case (state_q)
                CLEAR: begin
                    if (idx_q == {ADDR_W{1'b1}}) begin
                        state_q <= RUN;
                        ready_q <= 1'b1;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                RUN: begin
                    state_q <= RUN;
                end
                default: begin
                    state_q <= CLEAR;
                    idx_q   <= '0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the storage array has no reset term; contents become defined by
    // the CLEAR walk, which keeps it mappable to distributed RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rd_addr;
        assign rd_addr = ReadRegister[k*ADDR_W +: ADDR_W];

        regfile_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS)
        ) u_rd (
            .rd_addr_i (rd_addr),
            .rd_raw_i  (mem_q[rd_addr]),
            .run_i     (run),
            .wr_en_i   (user_wr),
            .wr_addr_i (WriteRegister),
            .wr_data_i (WriteData),
            .rd_data_o (ReadData[k*DATA_W +: DATA_W])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
// Drives a default instance (BYPASS=1) and a BYPASS=0 instance from the same
// inputs, plus a small 4-lane 16x16 instance, against a behavioural model.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared stimulus for the two 32x32 instances.
    logic        rst           = 1'b0;
    logic        RegWrite      = 1'b0;
    logic [4:0]  WriteRegister = '0;
    logic [31:0] WriteData     = '0;
    logic [9:0]  ReadRegister  = '0;
    logic [63:0] rd_a, rd_b;
    logic        ready_a, ready_b;

    // Small instance stimulus.
    logic        rst_c = 1'b0;
    logic        we_c  = 1'b0;
    logic [3:0]  wa_c  = '0;
    logic [15:0] wd_c  = '0;
    logic [15:0] rr_c  = '0;
    logic [63:0] rd_c;
    logic        ready_c;

    int errors = 0;
    int checks = 0;

    regfile_mp #(.BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister(ReadRegister), .ReadData(rd_a), .ready(ready_a)
    );

    regfile_mp #(.BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
        .WriteData(WriteData), .ReadRegister(ReadRegister), .ReadData(rd_b), .ready(ready_b)
    );

    regfile_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4), .BYPASS(1), .SP_IDX(13), .SP_INIT(252)) dut_c (
        .clk(clk), .rst(rst_c), .RegWrite(we_c), .WriteRegister(wa_c),
        .WriteData(wd_c), .ReadRegister(rr_c), .ReadData(rd_c), .ready(ready_c)
    );

    // Reference model for the 32-entry instances: number of initialisation
    // edges seen since reset, and the architectural register contents.
    logic [31:0] m_mem [32];
    int          m_cnt = 0;

    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
        if (m_cnt < 32) return 32'd0;
        if (a == 5'd0) return 32'd0;
        if (byp && RegWrite && WriteRegister == a) return WriteData;
        return m_mem[a];
    endfunction

    // Advance the model by one rising edge using the current inputs, then let
    // the edge happen; return 1 time unit after it.
    task automatic step();
        if (rst) begin
            m_cnt = 0;
        end else if (m_cnt < 32) begin
            m_mem[m_cnt] = (m_cnt == 29) ? 32'd252 : 32'd0;
            m_cnt++;
        end else if (RegWrite && WriteRegister != 5'd0) begin
            m_mem[WriteRegister] = WriteData;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; RegWrite = 1'b1; WriteRegister = 5'd3; WriteData = 32'hFFFF;
        step();
        checks++;
        if (ready_a !== 1'b0 || ready_b !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got a=%b b=%b expected 0", ready_a, ready_b);
        end
        rst = 1'b0;
        for (int e = 1; e <= 32; e++) begin
            ReadRegister = {5'd3, 5'($urandom)};
            #1;
            checks++;
            if (rd_a !== 64'd0 || rd_b !== 64'd0) begin
                errors++;
                $display("FAIL clear_reads_zero edge %0d: got a=%h b=%h expected 0", e, rd_a, rd_b);
            end
            step();
            checks++;
            if (ready_a !== (e == 32) || ready_b !== (e == 32)) begin
                errors++;
                $display("FAIL ready_timing edge %0d: got a=%b b=%b expected %b", e, ready_a, ready_b, e == 32);
            end
        end
        RegWrite = 1'b0;
        ReadRegister = {5'd8, 5'd29};
        #1;
        checks++;
        if (rd_a !== {32'd0, 32'd252} || rd_b !== {32'd0, 32'd252}) begin
            errors++;
            $display("FAIL init_sp_r8: got a=%h b=%h expected %h", rd_a, rd_b, {32'd0, 32'd252});
        end
        ReadRegister = {5'd3, 5'd3};
        #1;
        checks++;
        if (rd_a !== 64'd0) begin
            errors++;
            $display("FAIL clear_write_ignored: got %h expected 0", rd_a);
        end
    endtask

    task automatic test_write_read();
        RegWrite = 1'b1; WriteRegister = 5'd5; WriteData = 32'hDEADBEEF; ReadRegister = '0;
        step();
        WriteRegister = 5'd0; WriteData = 32'h1234;
        step();
        RegWrite = 1'b0;
        ReadRegister = {5'd5, 5'd5};
        #1;
        checks++;
        if (rd_a !== {2{32'hDEADBEEF}} || rd_b !== {2{32'hDEADBEEF}}) begin
            errors++;
            $display("FAIL write_r5: got a=%h b=%h expected %h", rd_a, rd_b, {2{32'hDEADBEEF}});
        end
        ReadRegister = {5'd5, 5'd0};
        #1;
        checks++;
        if (rd_a !== {32'hDEADBEEF, 32'd0}) begin
            errors++;
            $display("FAIL r0_discard: got %h expected %h", rd_a, {32'hDEADBEEF, 32'd0});
        end
    endtask

    task automatic test_bypass();
        RegWrite = 1'b1; WriteRegister = 5'd7; WriteData = 32'h11111111;
        step();
        WriteData = 32'hA5A5A5A5; ReadRegister = {5'd7, 5'd29};
        #1;
        checks++;
        if (rd_a !== {32'hA5A5A5A5, 32'd252}) begin
            errors++;
            $display("FAIL bypass_on: got %h expected %h", rd_a, {32'hA5A5A5A5, 32'd252});
        end
        checks++;
        if (rd_b !== {32'h11111111, 32'd252}) begin
            errors++;
            $display("FAIL bypass_off: got %h expected %h", rd_b, {32'h11111111, 32'd252});
        end
        step();
        RegWrite = 1'b0;
        #1;
        checks++;
        if (rd_b[63:32] !== 32'hA5A5A5A5) begin
            errors++;
            $display("FAIL bypass_off_after_edge: got %h expected a5a5a5a5", rd_b[63:32]);
        end
        // Forwarding must never expose a write to the zero register.
        RegWrite = 1'b1; WriteRegister = 5'd0; WriteData = 32'hFFFFFFFF; ReadRegister = '0;
        #1;
        checks++;
        if (rd_a !== 64'd0) begin
            errors++;
            $display("FAIL bypass_r0: got %h expected 0", rd_a);
        end
        step();
        RegWrite = 1'b0;
    endtask

    task automatic test_random();
        logic [4:0] a;
        for (int i = 0; i < 300; i++) begin
            RegWrite      = 1'($urandom_range(0, 1));
            WriteRegister = 5'($urandom);
            WriteData     = $urandom;
            for (int k = 0; k < 2; k++)
                ReadRegister[k*5 +: 5] = ($urandom_range(0, 3) == 0) ? WriteRegister : 5'($urandom);
            #1;
            for (int k = 0; k < 2; k++) begin
                a = ReadRegister[k*5 +: 5];
                checks++;
                if (rd_a[k*32 +: 32] !== exp_read(a, 1'b1)) begin
                    errors++;
                    $display("FAIL random_bypass i=%0d lane=%0d r%0d: got %h expected %h",
                             i, k, a, rd_a[k*32 +: 32], exp_read(a, 1'b1));
                end
                checks++;
                if (rd_b[k*32 +: 32] !== exp_read(a, 1'b0)) begin
                    errors++;
                    $display("FAIL random_nobypass i=%0d lane=%0d r%0d: got %h expected %h",
                             i, k, a, rd_b[k*32 +: 32], exp_read(a, 1'b0));
                end
            end
            step();
        end
        RegWrite = 1'b0;
    endtask

    task automatic test_reset_mid_clear();
        int n;
        RegWrite = 1'b1; WriteRegister = 5'd10; WriteData = 32'h55;
        step();
        RegWrite = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n = 0;
        while (ready_a !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n != 32) begin
            errors++;
            $display("FAIL restart_ready_edges: got %0d expected 32", n);
        end
        ReadRegister = {5'd10, 5'd29};
        #1;
        checks++;
        if (rd_a !== {32'd0, 32'd252} || rd_b !== {32'd0, 32'd252}) begin
            errors++;
            $display("FAIL restart_r10: got a=%h b=%h expected %h", rd_a, rd_b, {32'd0, 32'd252});
        end
    endtask

    task automatic test_small();
        int n;
        rst_c = 1'b1;
        step();
        rst_c = 1'b0;
        n = 0;
        while (ready_c !== 1'b1 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (n != 16) begin
            errors++;
            $display("FAIL small_ready_edges: got %0d expected 16", n);
        end
        we_c = 1'b1;
        for (int r = 1; r <= 4; r++) begin
            wa_c = 4'(r);
            wd_c = 16'(r);
            step();
        end
        we_c = 1'b0;
        rr_c = {4'd4, 4'd3, 4'd2, 4'd1};
        #1;
        checks++;
        if (rd_c !== {16'd4, 16'd3, 16'd2, 16'd1}) begin
            errors++;
            $display("FAIL small_four_lanes: got %h expected %h", rd_c, {16'd4, 16'd3, 16'd2, 16'd1});
        end
        rr_c = {4'd0, 4'd15, 4'd13, 4'd13};
        #1;
        checks++;
        if (rd_c !== {16'd0, 16'd0, 16'd252, 16'd252}) begin
            errors++;
            $display("FAIL small_sp_r15_r0: got %h expected %h", rd_c, {16'd0, 16'd0, 16'd252, 16'd252});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        #2;
        test_reset();
        test_write_read();
        test_bypass();
        test_random();
        test_reset_mid_clear();
        test_small();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 5: register index width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL have parameter NUM_RD, default 2, legal 1..4: number of independent read ports.
REQ-004 SHALL have parameter BYPASS, default 1: 1 = same-cycle write-to-read forwarding, 0 = none.
REQ-005 SHALL have parameters SP_IDX (default 29) and SP_INIT (default 252): the stack-pointer entry and its post-reset value.
REQ-006 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-008 SHALL have port RegWrite, input, 1: write enable.
REQ-009 SHALL have port WriteRegister, input, ADDR_W: write index.
REQ-010 SHALL have port WriteData, input, DATA_W: write data.
REQ-011 SHALL have port ReadRegister, input, NUM_RD*ADDR_W: read indices, port k at bits [k*ADDR_W +: ADDR_W].
REQ-012 SHALL have port ReadData, output, NUM_RD*DATA_W: read data, port k at bits [k*DATA_W +: DATA_W].
REQ-013 SHALL have port ready, output, 1: high once initialisation completes.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR (initialising) and RUN (normal operation).
REQ-015 In CLEAR, each cycle SHALL write entry idx with SP_INIT if idx==SP_IDX, else 0, then increment idx.
REQ-016 On the edge where CLEAR writes idx==DEPTH-1, SHALL move to RUN and set ready=1; ready is high after exactly DEPTH edges with rst low.
REQ-017 In CLEAR, RegWrite SHALL be ignored and every ReadData lane SHALL read 0.
REQ-018 In RUN, when RegWrite=1 and WriteRegister!=0, SHALL store WriteData at that index on the rising edge.
REQ-019 Writes to index 0 SHALL be discarded; reads of index 0 SHALL return 0 on every port in all states.
REQ-020 Reads SHALL be combinational: ReadData lane k reflects the current array content at ReadRegister lane k.
REQ-021 With BYPASS=1, in RUN, a lane whose nonzero index equals WriteRegister while RegWrite=1 SHALL return WriteData in the same cycle.
REQ-022 With BYPASS=0, such a lane SHALL return the old stored value until the edge.
REQ-023 Several lanes addressing the same index SHALL all return identical data.
REQ-024 The idx counter SHALL be ADDR_W bits wide; it does not wrap because CLEAR exits at DEPTH-1.

Reset
REQ-025 While rst=1: state=CLEAR, idx=0, ready=0; no array write occurs; RegWrite is ignored.
REQ-026 rst asserted mid-CLEAR or in RUN SHALL restart initialisation from idx=0 on the following rst-low edges.
REQ-027 The block SHALL not rely on initial blocks for functional values; the array holds defined contents only after CLEAR completes.

Structure
REQ-028 Package regfile_pkg SHALL hold the FSM state enum (CLEAR, RUN) and the default DATA_W, ADDR_W, SP_IDX, SP_INIT constants.
REQ-029 Per-lane zero-check and bypass mux SHALL be the sub-module regfile_read_port, instantiated NUM_RD times via generate.
REQ-030 The storage array SHALL have one write port, so it maps to distributed RAM.

Verification
REQ-031 Pulse rst 1 cycle, then hold low -> ready=0 for 31 edges and 1 after edge 32; reads of r29=252 and r8=0.
REQ-032 In RUN, write r5=0xDEADBEEF, then read lanes 0 and 1 at r5 -> both 0xDEADBEEF; write r0=0x1234 -> r0 reads 0.
REQ-033 BYPASS=1: write r7=0xA5A5A5A5 while lane 1 reads r7 in the same cycle -> lane 1=0xA5A5A5A5 before the edge; BYPASS=0 -> old value.
REQ-034 During CLEAR, RegWrite=1 to r3=0xFFFF -> ignored; after ready, r3=0 and all lanes read 0 throughout CLEAR.
REQ-035 Assert rst at CLEAR idx=10 after r10 was previously 0x55 -> ready rises 32 edges after rst drops; r10=0.
REQ-036 NUM_RD=4, ADDR_W=4, DATA_W=16: four lanes read r1..r4 after writing 1..4 -> 0x0001..0x0004; ready after 16 edges.
